// File: rtl/regfile_sb_if.sv
// Decode/writeback/debug bundle for regfile_sb: read, write, reservation and scan signals.
// The master side (pipeline or bench) drives addresses and data; the slave side is the register file.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic [AW-1:0]   A1;
  logic [AW-1:0]   A2;
  logic [AW-1:0]   A3;
  logic [XLEN-1:0] WD3;
  logic            WE3;
  logic [XLEN-1:0] RD1;
  logic [XLEN-1:0] RD2;
  logic            IE;
  logic [AW-1:0]   IA;
  logic            BUSY1;
  logic            BUSY2;
  logic            DBG_START;
  logic            DBG_VALID;
  logic [AW-1:0]   DBG_IDX;
  logic [XLEN-1:0] DBG_DATA;
  logic            DBG_DONE;

  modport master (
    output A1, A2, A3, WD3, WE3, IE, IA, DBG_START,
    input  RD1, RD2, BUSY1, BUSY2, DBG_VALID, DBG_IDX, DBG_DATA, DBG_DONE
  );

  modport slave (
    input  A1, A2, A3, WD3, WE3, IE, IA, DBG_START,
    output RD1, RD2, BUSY1, BUSY2, DBG_VALID, DBG_IDX, DBG_DATA, DBG_DONE
  );
endinterface

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with per-register busy scoreboard, optional write-to-read
// bypass and a sequential debug dump of every architectural register.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  regfile_sb_if.slave  bus
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} scan_state_t;

  // Full 2**AW address space is decoded; x0 and unimplemented slots are tied to zero.
  logic [XLEN-1:0] reg_val [DEPTH];
  logic [DEPTH-1:0] busy_val;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == 0 || gi >= NREG) begin : g_const
        assign reg_val[gi]  = '0;
        assign busy_val[gi] = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] q_reg;
        logic            busy_reg;
        logic            wr_hit;
        logic            rsv_hit;

        assign wr_hit  = bus.WE3 && (bus.A3 == AW'(gi));
        assign rsv_hit = bus.IE && (bus.IA == AW'(gi));

        // A reservation in the same cycle as a writeback is newer, so it wins.
        always_ff @(posedge CLK or negedge RST_N) begin
          if (!RST_N) begin
            q_reg    <= '0;
            busy_reg <= 1'b0;
          end else begin
            if (wr_hit) q_reg <= bus.WD3;
            if (rsv_hit)     busy_reg <= 1'b1;
            else if (wr_hit) busy_reg <= 1'b0;
          end
        end

        assign reg_val[gi]  = q_reg;
        assign busy_val[gi] = busy_reg;
      end
    end
  endgenerate

  logic wr_live;
  logic byp1;
  logic byp2;

  assign wr_live = bus.WE3 && (bus.A3 != '0) && (32'(bus.A3) < 32'(NREG));
  assign byp1    = (BYPASS != 0) && wr_live && (bus.A3 == bus.A1);
  assign byp2    = (BYPASS != 0) && wr_live && (bus.A3 == bus.A2);

  assign bus.RD1   = byp1 ? bus.WD3 : reg_val[bus.A1];
  assign bus.RD2   = byp2 ? bus.WD3 : reg_val[bus.A2];
  assign bus.BUSY1 = byp1 ? 1'b0 : busy_val[bus.A1];
  assign bus.BUSY2 = byp2 ? 1'b0 : busy_val[bus.A2];

  scan_state_t     state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            dbg_valid;
  logic            dbg_done;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    dbg_valid  = 1'b0;
    dbg_done   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.DBG_START) begin
          state_next = SCAN;
          idx_next   = '0;
        end
      end
      SCAN: begin
        dbg_valid = 1'b1;
        if (idx_reg == LAST_IDX) state_next = DONE;
        else                     idx_next   = idx_reg + 1'b1;
      end
      DONE: begin
        dbg_done   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Dump shows committed content only; a same-cycle write to idx is not forwarded.
  assign bus.DBG_VALID = dbg_valid;
  assign bus.DBG_DONE  = dbg_done;
  assign bus.DBG_IDX   = idx_reg;
  assign bus.DBG_DATA  = dbg_valid ? reg_val[idx_reg] : '0;

endmodule
